ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (16..64, even).
REQ-002 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-003 SHALL have clock port clk, input, 1, sole clock, rising edge; reset is synchronous and active-low.
REQ-004 SHALL have reset port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have in_valid, input, 1, request present.
REQ-006 SHALL have in_ready, output, 1, unit can accept request.
REQ-007 SHALL have op, input, 3, RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-008 SHALL have fwd_a_sel, fwd_b_sel, input, 2 each, operand source (00 register, 01 writeback, 10 memory, 11 zero).
REQ-009 SHALL have rd1, rd2, result_w, alu_result_m, input, XLEN each, operand candidates.
REQ-010 SHALL have in_tag, input, TAG_W, destination tag; out_tag, output, TAG_W, captured tag.
REQ-011 SHALL have flush, input, 1, abort in-flight operation.
REQ-012 SHALL have out_valid, output, 1; out_ready, input, 1; result, output, XLEN; busy, output, 1.

Function
REQ-013 SHALL resolve operands A/B combinationally from fwd_*_sel, captured only on accept (in_valid && in_ready).
REQ-014 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready = 1 only in IDLE; busy = 1 in CALC or DONE.
REQ-015 SHALL in CALC perform radix-2 iteration, one bit per cycle, exactly XLEN cycles, on operand magnitudes with sign fixed up on the DONE transition.
REQ-016 SHALL assert out_valid the cycle after the last CALC cycle: accept at edge N gives out_valid during cycle N+XLEN+1.
REQ-017 SHALL hold result and out_tag stable while out_valid && !out_ready; leave DONE on the edge where out_ready = 1.
REQ-018 SHALL not accept a new request in the same cycle as DONE handoff; the next accept occurs no earlier than the following IDLE cycle.
REQ-019 SHALL return the low XLEN bits for MUL, and the high XLEN bits of the 2*XLEN product for MULH (signed x signed), MULHSU (signed x unsigned), and MULHU (unsigned x unsigned).
REQ-020 SHALL return the quotient truncated toward zero for DIV/DIVU, and for REM/REMU a remainder whose sign equals the dividend's.
REQ-021 SHALL on divisor = 0 skip CALC (IDLE -> DONE in one cycle): quotient all ones, remainder = dividend.
REQ-022 SHALL on signed overflow (dividend = most-negative, divisor = -1) skip CALC: quotient = dividend, remainder = 0.
REQ-023 SHALL on flush force IDLE at the next edge from any state, deassert out_valid, and discard the result.
REQ-024 SHALL let flush win over a same-cycle in_valid in IDLE (request not accepted).
REQ-025 SHALL keep result and out_tag unchanged (last value) outside DONE; they are valid only when out_valid = 1.

Reset
REQ-026 SHALL when rst_n = 0 at a clock edge, from any state including mid-CALC, enter IDLE with out_valid = 0, busy = 0, result = 0, out_tag = 0, iteration counter = 0.
REQ-027 SHALL have in_ready = 1 in the first cycle after reset is released.

Structure
REQ-028 SHALL place the op encodings, forward-select encodings and FSM state type in shared package ex_pkg.
REQ-029 SHALL instantiate the operand forwarding mux as sub-module ex_fwd_mux, parametrised by XLEN, one instance per operand.
REQ-030 SHALL size the iteration counter as clog2(XLEN)+1 bits and share one adder/subtractor between the multiply and divide paths.

Verification
REQ-031 SHALL cover MUL of 7 and 0xFFFFFFFD (-3) -> result 0xFFFFFFEB, out_valid at cycle 33 after accept.
REQ-032 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 SHALL cover DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD, and REM of the same operands -> 0xFFFFFFFF.
REQ-034 SHALL cover DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with out_valid one cycle after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-035 SHALL cover flush asserted at CALC cycle 10 -> IDLE next edge, no out_valid, and a new MUL 3x4 accepted afterward -> 12.
REQ-036 SHALL cover out_ready held 0 for 5 cycles in DONE with fwd_a_sel = 10 (alu_result_m = 6), rd2 = 3, DIVU -> result 2 and out_tag stable throughout, released on out_ready = 1.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared op, forward-select and FSM encodings for the multiply/divide unit
package ex_pkg;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;
    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_ZERO = 2'b11
    } fwd_e;
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;
endpackage

// File: rtl/ex_fwd_mux.sv
// ex_fwd_mux: selects one operand from register, writeback, memory or zero
module ex_fwd_mux import ex_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] rd,
    input  logic [XLEN-1:0] wb,
    input  logic [XLEN-1:0] mem,
    output logic [XLEN-1:0] res
);
    fwd_e s;
    always_comb begin
        s = fwd_e'(sel);
        res = s == FWD_REG ? rd : s == FWD_WB ? wb : s == FWD_MEM ? mem : '0;
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide, one bit per cycle on operand magnitudes
module ex_muldiv_unit import ex_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [1:0]       fwd_a_sel,
    input  logic [1:0]       fwd_b_sel,
    input  logic [XLEN-1:0]  rd1,
    input  logic [XLEN-1:0]  rd2,
    input  logic [XLEN-1:0]  result_w,
    input  logic [XLEN-1:0]  alu_result_m,
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             busy
);
    localparam int CW = $clog2(XLEN) + 1;
    logic [XLEN-1:0] a, b, am, bm;
    ex_fwd_mux #(.XLEN(XLEN)) u_fwd_a (.sel(fwd_a_sel), .rd(rd1), .wb(result_w), .mem(alu_result_m), .res(a));
    ex_fwd_mux #(.XLEN(XLEN)) u_fwd_b (.sel(fwd_b_sel), .rd(rd2), .wb(result_w), .mem(alu_result_m), .res(b));
    state_e state;
    op_e opc;
    logic [CW-1:0] cnt;
    logic [XLEN-1:0] hi, lo, m, nhi, nlo, q, r, fin;
    logic [TAG_W-1:0] tag;
    logic is_div, neg_p, neg_r, alt, sa, sb, an, bn, dbz, ovf, ok;
    logic [XLEN:0] sh;
    logic [XLEN+1:0] x, y, sum;
    logic [2*XLEN-1:0] sp;
    always_comb begin
        opc = op_e'(op);
        sa = opc == OP_MULH || opc == OP_MULHSU || opc == OP_DIV || opc == OP_REM;
        sb = opc == OP_MULH || opc == OP_DIV || opc == OP_REM;
        an = sa & a[XLEN-1];
        bn = sb & b[XLEN-1];
        am = an ? -a : a;
        bm = bn ? -b : b;
        dbz = op[2] && b == '0;
        ovf = op[2] && !op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && &b;
    end
    // One shared adder: add-and-shift for multiply, trial subtract for divide
    always_comb begin
        sh = {hi, lo[XLEN-1]};
        x = is_div ? {1'b0, sh} : {2'b0, hi};
        y = (is_div || lo[0]) ? {2'b0, m} : '0;
        sum = x + (y ^ {(XLEN+2){is_div}}) + {{(XLEN+1){1'b0}}, is_div};
        ok = !sum[XLEN+1];
        nhi = is_div ? (ok ? sum[XLEN-1:0] : sh[XLEN-1:0]) : sum[XLEN:1];
        nlo = is_div ? {lo[XLEN-2:0], ok} : {sum[0], lo[XLEN-1:1]};
        sp = neg_p ? -{nhi, nlo} : {nhi, nlo};
        q = neg_p ? -nlo : nlo;
        r = neg_r ? -nhi : nhi;
        fin = is_div ? (alt ? r : q) : (alt ? sp[2*XLEN-1:XLEN] : sp[XLEN-1:0]);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            busy <= 1'b0;
            result <= '0;
            out_tag <= '0;
            tag <= '0;
            cnt <= '0;
            hi <= '0;
            lo <= '0;
            m <= '0;
            is_div <= 1'b0;
            neg_p <= 1'b0;
            neg_r <= 1'b0;
            alt <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    is_div <= op[2];
                    neg_p <= an ^ bn;
                    neg_r <= an;
                    alt <= op[2] ? op[1] : |op[1:0];
                    cnt <= '0;
                    tag <= in_tag;
                    hi <= '0;
                    lo <= op[2] ? am : bm;
                    m <= op[2] ? bm : am;
                    in_ready <= 1'b0;
                    busy <= 1'b1;
                    if (dbz || ovf) begin
                        state <= S_DONE;
                        out_valid <= 1'b1;
                        out_tag <= in_tag;
                        result <= dbz ? (op[1] ? a : '1) : (op[1] ? '0 : a);
                    end else begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    hi <= nhi;
                    lo <= nlo;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1)) begin
                        state <= S_DONE;
                        out_valid <= 1'b1;
                        result <= fin;
                        out_tag <= tag;
                    end
                end
                S_DONE: if (out_ready) begin
                    state <= S_IDLE;
                    out_valid <= 1'b0;
                    busy <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    out_valid <= 1'b0;
                    busy <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed vectors with hand-computed results for ex_muldiv_unit
module tb_ex_muldiv_unit;
    import ex_pkg::*;
    logic clk = 0, rst_n = 0, in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0, busy;
    logic [2:0] op = 0;
    logic [1:0] fwd_a_sel = 0, fwd_b_sel = 0;
    logic [31:0] rd1 = 0, rd2 = 0, result_w = 0, alu_result_m = 0, result;
    logic [4:0] in_tag = 0, out_tag;
    int checks = 0, errors = 0;
    logic seen;
    always #5 clk = ~clk;
    ex_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .rd1(rd1), .rd2(rd2),
        .result_w(result_w), .alu_result_m(alu_result_m), .in_tag(in_tag), .out_tag(out_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask
    task automatic drive(input logic [2:0] o, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [31:0] va, input logic [31:0] vb, input logic [4:0] t);
        rd1 = 32'hDEAD_0001; rd2 = 32'hDEAD_0002; result_w = 32'hDEAD_0003; alu_result_m = 32'hDEAD_0004;
        case (sa)
            2'b00: rd1 = va;
            2'b01: result_w = va;
            2'b10: alu_result_m = va;
            default: ;
        endcase
        case (sb)
            2'b00: rd2 = vb;
            2'b01: result_w = vb;
            2'b10: alu_result_m = vb;
            default: ;
        endcase
        op = o; fwd_a_sel = sa; fwd_b_sel = sb; in_tag = t; in_valid = 1;
    endtask
    task automatic run(input string name, input logic [2:0] o, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [31:0] va, input logic [31:0] vb, input logic [4:0] t,
                       input logic [31:0] exp, input int lat_exp, input int hold);
        int lat;
        @(negedge clk);
        drive(o, sa, sb, va, vb, t);
        check({name, ".rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, ".lat"}, lat, lat_exp);
        check({name, ".res"}, result, exp);
        check({name, ".tag"}, out_tag, t);
        check({name, ".busy"}, {in_ready, busy}, 2'b01);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, ".hold"}, {out_valid, result, out_tag}, {1'b1, exp, t});
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check({name, ".done"}, {out_valid, in_ready, busy, result}, {3'b010, exp});
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1 check("rst.outs", {in_ready, out_valid, busy, result, out_tag}, {3'b100, 32'h0, 5'h0});
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        check("rst.rdy", {in_ready, busy}, 2'b10);
        run("mul",    OP_MUL,    2'b00, 2'b00, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33, 0);
        run("mulh",   OP_MULH,   2'b01, 2'b01, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33, 0);
        run("mulhu",  OP_MULHU,  2'b00, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 33, 0);
        run("mulhsu", OP_MULHSU, 2'b10, 2'b00, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, 33, 0);
        run("mulh2",  OP_MULH,   2'b00, 2'b00, 32'hFFFFFFFD, 32'd7,        5'd5,  32'hFFFFFFFF, 33, 0);
        run("mulhu2", OP_MULHU,  2'b00, 2'b00, 32'h00010000, 32'h00010000, 5'd6,  32'h00000001, 33, 0);
        run("mulz",   OP_MUL,    2'b00, 2'b11, 32'h12345678, 32'h0,        5'd7,  32'h00000000, 33, 0);
        run("div",    OP_DIV,    2'b00, 2'b00, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 33, 0);
        run("rem",    OP_REM,    2'b00, 2'b00, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 33, 0);
        run("div2",   OP_DIV,    2'b00, 2'b00, 32'd7,        32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 33, 0);
        run("rem2",   OP_REM,    2'b00, 2'b00, 32'd7,        32'hFFFFFFFE, 5'd11, 32'h00000001, 33, 0);
        run("divu",   OP_DIVU,   2'b01, 2'b00, 32'd100,      32'd7,        5'd12, 32'd14,       33, 0);
        run("remu",   OP_REMU,   2'b00, 2'b10, 32'd100,      32'd7,        5'd13, 32'd2,        33, 0);
        run("divu0",  OP_DIVU,   2'b00, 2'b00, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1,  0);
        run("rem0",   OP_REM,    2'b00, 2'b00, 32'd5,        32'd0,        5'd15, 32'd5,        1,  0);
        run("divz",   OP_DIVU,   2'b00, 2'b11, 32'd9,        32'd0,        5'd16, 32'hFFFFFFFF, 1,  0);
        run("ovf",    OP_DIV,    2'b00, 2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1,  0);
        run("ovfrem", OP_REM,    2'b00, 2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h00000000, 1,  0);
        run("hold",   OP_DIVU,   2'b10, 2'b00, 32'd6,        32'd3,        5'd19, 32'd2,        33, 5);
        // flush on the tenth CALC cycle discards the multiply
        @(negedge clk);
        drive(OP_MUL, 2'b00, 2'b00, 32'd5, 32'd5, 5'd20);
        @(posedge clk); #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        #1 check("fl.calc", {busy, in_ready}, 2'b10);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        check("fl.idle", {out_valid, busy, in_ready}, 3'b001);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check("fl.nov", {seen, result, out_tag}, {1'b0, 32'd2, 5'd19});
        run("mul34", OP_MUL, 2'b00, 2'b00, 32'd3, 32'd4, 5'd21, 32'd12, 33, 0);
        // flush beats a same-cycle request in IDLE
        @(negedge clk);
        drive(OP_MUL, 2'b00, 2'b00, 32'd2, 32'd2, 5'd22);
        flush = 1;
        @(posedge clk); #1;
        in_valid = 0; flush = 0;
        check("fl.win", {busy, in_ready}, 2'b01);
        @(posedge clk); #1;
        check("fl.win2", {busy, out_valid}, 2'b00);
        // reset in the middle of CALC
        @(negedge clk);
        drive(OP_DIVU, 2'b00, 2'b00, 32'd50, 32'd5, 5'd23);
        @(posedge clk); #1;
        in_valid = 0;
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        check("rst.mid", {in_ready, out_valid, busy, result, out_tag}, {3'b100, 32'h0, 5'h0});
        run("post", OP_DIVU, 2'b00, 2'b00, 32'd50, 32'd5, 5'd24, 32'd10, 33, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
